// File: rtl/score_text_overlay_if.sv
// ============================================================================
//  score_text_overlay_if
//  Pixel, score and glyph-ROM signals of the Pong text-overlay front end.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface score_text_overlay_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_start;
    logic [6:0] score_left;
    logic [6:0] score_right;
    logic       score_valid;
    logic [1:0] msg_sel;
    logic       glyph_pixel;
    logic [5:0] char_index;
    logic [2:0] glyph_row;
    logic [2:0] glyph_column;
    logic       overlay_on;
    logic       busy;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start,
        output score_left, score_right, score_valid, msg_sel, glyph_pixel,
        input  char_index, glyph_row, glyph_column, overlay_on, busy
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start,
        input  score_left, score_right, score_valid, msg_sel, glyph_pixel,
        output char_index, glyph_row, glyph_column, overlay_on, busy
    );
endinterface

`default_nettype wire

// File: rtl/score_text_overlay.sv
// ============================================================================
//  score_text_overlay
//  Maps VGA pixels to text cells for the glyph ROM and converts scores to BCD.
//  Optional macro MSG_BLINK_EN blinks the message line (32 frames on/off).
//  Rev 1.0
// ============================================================================
`default_nettype none

module score_text_overlay #(
    parameter int SCALE_LOG2 = 1,
    parameter int SCORE_ROW  = 1,
    parameter int SCORE_COL  = 16,
    parameter int MSG_ROW    = 14,
    parameter int MSG_COL    = 14
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    score_text_overlay_if.slave bus
);

    localparam logic [9:0] C_SCORE_ROW = 10'(SCORE_ROW);
    localparam logic [9:0] C_SCORE_COL = 10'(SCORE_COL);
    localparam logic [9:0] C_MSG_ROW   = 10'(MSG_ROW);
    localparam logic [9:0] C_MSG_COL   = 10'(MSG_COL);
    localparam logic [5:0] C_BLANK     = 6'd31;
    localparam logic [5:0] C_DIGIT0    = 6'd13;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT_L, S_SHIFT_R, S_WAIT_FRAME
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cap_l, r_cap_r, r_pend_l, r_pend_r;
    logic        r_pending;
    logic [14:0] r_dd;
    logic [2:0]  r_cnt;
    logic [7:0]  r_shadow_l, r_shadow_r, r_disp_l, r_disp_r;
    logic        r_busy;
    logic        r_v1;

    logic [9:0]  w_cell_x, w_cell_y, w_dsx, w_dmx;
    logic [2:0]  w_off_x, w_off_y;
    logic [5:0]  w_char;
    logic [6:0]  w_sat_l, w_sat_r;
    logic [14:0] w_dd_next;
    logic        w_msg_show;

    // BCD nibbles live in [14:7], the binary operand shifts out of [6:0].
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [5:0] msg1_char(input logic [3:0] i);
        case (i)
            4'd0:    return 6'd0;
            4'd1:    return 6'd1;
            4'd2:    return 6'd2;
            4'd3,
            4'd4,
            4'd6:    return 6'd3;
            4'd7,
            4'd10:   return 6'd5;
            4'd8:    return 6'd4;
            4'd9:    return 6'd1;
            default: return C_BLANK;
        endcase
    endfunction

    function automatic logic [5:0] msg2_char(input logic [2:0] i);
        case (i)
            3'd0:    return 6'd0;
            3'd1:    return 6'd4;
            3'd2:    return 6'd8;
            3'd3:    return 6'd3;
            3'd4:    return 6'd2;
            default: return C_BLANK;
        endcase
    endfunction

    assign w_cell_x  = bus.pixel_x >> (3 + SCALE_LOG2);
    assign w_cell_y  = bus.pixel_y >> (3 + SCALE_LOG2);
    assign w_off_x   = 3'(bus.pixel_x >> SCALE_LOG2);
    assign w_off_y   = 3'(bus.pixel_y >> SCALE_LOG2);
    assign w_dsx     = w_cell_x - C_SCORE_COL;
    assign w_dmx     = w_cell_x - C_MSG_COL;
    assign w_sat_l   = (bus.score_left  > 7'd99) ? 7'd99 : bus.score_left;
    assign w_sat_r   = (bus.score_right > 7'd99) ? 7'd99 : bus.score_right;
    assign w_dd_next = dd_step(r_dd);
    assign bus.busy  = r_busy;

`ifdef MSG_BLINK_EN
    logic [5:0] r_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_blink <= 6'd0;
        else if (bus.frame_start) r_blink <= r_blink + 6'd1;
    end

    assign w_msg_show = ~r_blink[5];
`else
    assign w_msg_show = 1'b1;
`endif

    always_comb begin
        w_char = C_BLANK;
        if (bus.video_on) begin
            if (w_cell_y == C_SCORE_ROW && w_dsx < 10'd5) begin
                case (w_dsx[2:0])
                    3'd0:    w_char = C_DIGIT0 + {2'b00, r_disp_l[7:4]};
                    3'd1:    w_char = C_DIGIT0 + {2'b00, r_disp_l[3:0]};
                    3'd2:    w_char = 6'd12;
                    3'd3:    w_char = C_DIGIT0 + {2'b00, r_disp_r[7:4]};
                    default: w_char = C_DIGIT0 + {2'b00, r_disp_r[3:0]};
                endcase
            end else if (w_cell_y == C_MSG_ROW && w_msg_show) begin
                if (bus.msg_sel == 2'd1 && w_dmx < 10'd11)
                    w_char = msg1_char(w_dmx[3:0]);
                else if (bus.msg_sel == 2'd2 && w_dmx < 10'd5)
                    w_char = msg2_char(w_dmx[2:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.char_index   <= C_BLANK;
            bus.glyph_row    <= 3'd0;
            bus.glyph_column <= 3'd0;
            bus.overlay_on   <= 1'b0;
            r_v1             <= 1'b0;
        end else begin
            bus.char_index   <= w_char;
            bus.glyph_row    <= w_off_y;
            bus.glyph_column <= w_off_x;
            r_v1             <= bus.video_on;
            bus.overlay_on   <= bus.glyph_pixel & r_v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cap_l    <= 7'd0;
            r_cap_r    <= 7'd0;
            r_pend_l   <= 7'd0;
            r_pend_r   <= 7'd0;
            r_pending  <= 1'b0;
            r_dd       <= 15'd0;
            r_cnt      <= 3'd0;
            r_shadow_l <= 8'd0;
            r_shadow_r <= 8'd0;
            r_disp_l   <= 8'd0;
            r_disp_r   <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.score_valid) begin
                        r_cap_l <= w_sat_l;
                        r_cap_r <= w_sat_r;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_dd    <= {8'd0, r_cap_l};
                    r_cnt   <= 3'd0;
                    r_state <= S_SHIFT_L;
                end
                S_SHIFT_L: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_dd  <= w_dd_next;
                    if (r_cnt == 3'd6) begin
                        r_shadow_l <= w_dd_next[14:7];
                        r_dd       <= {8'd0, r_cap_r};
                        r_cnt      <= 3'd0;
                        r_state    <= S_SHIFT_R;
                    end
                end
                S_SHIFT_R: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_dd  <= w_dd_next;
                    if (r_cnt == 3'd6) begin
                        r_shadow_r <= w_dd_next[14:7];
                        r_state    <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (bus.frame_start) begin
                        r_disp_l <= r_shadow_l;
                        r_disp_r <= r_shadow_r;
                        // A capture arriving with the commit supersedes any older pending one.
                        if (bus.score_valid) begin
                            r_cap_l <= w_sat_l;
                            r_cap_r <= w_sat_r;
                            r_state <= S_LOAD;
                        end else if (r_pending) begin
                            r_cap_l <= r_pend_l;
                            r_cap_r <= r_pend_r;
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            if (bus.score_valid && r_state != S_IDLE &&
                !(r_state == S_WAIT_FRAME && bus.frame_start)) begin
                r_pend_l  <= w_sat_l;
                r_pend_r  <= w_sat_r;
                r_pending <= 1'b1;
            end else if (r_state == S_WAIT_FRAME && bus.frame_start) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_text_overlay.sv
// ============================================================================
//  tb_score_text_overlay
//  Directed and randomized checks of score_text_overlay against a queue model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_text_overlay;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    score_text_overlay_if bus ();

    score_text_overlay dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scores waiting to be displayed: head is converting, [1] is the pending capture.
    int q[$];
    int m_dl = 0, m_dr = 0;
    int frames = 0;
    int von_prev = 0;
    int quiet = 0;
    int msg1 [11] = '{0, 1, 2, 3, 3, 31, 3, 5, 4, 1, 5};
    int msg2 [5]  = '{0, 4, 8, 3, 2};

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic int exp_char(int x, int y, int von, int ms);
        int cx, cy, k;
        bit show;
        cx = x / 16;
        cy = y / 16;
`ifdef MSG_BLINK_EN
        show = ((frames % 64) < 32);
`else
        show = 1'b1;
`endif
        if (von == 0) return 31;
        if (cy == 1 && cx >= 16 && cx <= 20) begin
            k = cx - 16;
            case (k)
                0:       return 13 + m_dl / 10;
                1:       return 13 + m_dl % 10;
                2:       return 12;
                3:       return 13 + m_dr / 10;
                default: return 13 + m_dr % 10;
            endcase
        end
        if (cy == 14 && show) begin
            k = cx - 14;
            if (ms == 1 && k >= 0 && k < 11) return msg1[k];
            if (ms == 2 && k >= 0 && k < 5)  return msg2[k];
        end
        return 31;
    endfunction

    task automatic tick();
        int ex, ey, ec, er, ecl, eov, nv, was;
        bit sv, fs;
        ex  = int'(bus.pixel_x);
        ey  = int'(bus.pixel_y);
        ec  = exp_char(ex, ey, int'(bus.video_on), int'(bus.msg_sel));
        er  = (ey / 2) % 8;
        ecl = (ex / 2) % 8;
        eov = int'(bus.glyph_pixel) & von_prev;
        sv  = bus.score_valid;
        fs  = bus.frame_start;
        nv  = sat(int'(bus.score_left)) * 100 + sat(int'(bus.score_right));
        @(posedge clk);
        was = q.size();
        if (sv) begin
            if (q.size() < 2) q.push_back(nv);
            else q[1] = nv;
        end
        if (fs) begin
            frames++;
            if (was > 0) begin
                nv   = q.pop_front();
                m_dl = nv / 100;
                m_dr = nv % 100;
            end
        end
        von_prev = int'(bus.video_on);
        quiet    = (sv || fs) ? 0 : quiet + 1;
        #1;
        chk("char_index",   int'(bus.char_index),   ec);
        chk("glyph_row",    int'(bus.glyph_row),    er);
        chk("glyph_column", int'(bus.glyph_column), ecl);
        chk("overlay_on",   int'(bus.overlay_on),   eov);
        chk("busy",         int'(bus.busy),         (q.size() != 0) ? 1 : 0);
        bus.frame_start = 1'b0;
        bus.score_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.score_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_char_index",   int'(bus.char_index),   31);
        chk("rst_glyph_row",    int'(bus.glyph_row),    0);
        chk("rst_glyph_column", int'(bus.glyph_column), 0);
        chk("rst_overlay_on",   int'(bus.overlay_on),   0);
        chk("rst_busy",         int'(bus.busy),         0);
        q.delete();
        m_dl = 0; m_dr = 0; frames = 0; von_prev = 0; quiet = 0;
        rst_n = 1'b1;
    endtask

    task automatic set_pix(int x, int y, bit von, bit gp);
        bus.pixel_x     = 10'(x);
        bus.pixel_y     = 10'(y);
        bus.video_on    = von;
        bus.glyph_pixel = gp;
    endtask

    task automatic post_scores(int l, int r);
        bus.score_left  = 7'(l);
        bus.score_right = 7'(r);
        bus.score_valid = 1'b1;
        tick();
    endtask

    task automatic frame_and_sweep();
        repeat (22) tick();
        bus.frame_start = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            set_pix(256 + 16 * k, 16, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        set_pix(0, 0, 1'b0, 1'b0);
        bus.frame_start = 1'b0;
        bus.score_left  = 7'd0;
        bus.score_right = 7'd0;
        bus.score_valid = 1'b0;
        bus.msg_sel     = 2'd0;
        do_reset();

        // Left tens cell, offset 0, right after reset release.
        set_pix(256, 16, 1'b1, 1'b0);
        tick();
        chk("first_cell_index", int'(bus.char_index), 13);
        tick();

        post_scores(42, 7);
        frame_and_sweep();
        chk("score_42_7", m_dl * 100 + m_dr, 4207);

        post_scores(120, 3);
        frame_and_sweep();

        // Second capture lands while the first is still shifting.
        post_scores(33, 88);
        repeat (3) tick();
        post_scores(5, 6);
        frame_and_sweep();
        frame_and_sweep();

        // Capture coincident with the commit.
        post_scores(11, 22);
        repeat (22) tick();
        bus.frame_start = 1'b1;
        post_scores(60, 70);
        frame_and_sweep();

        // Message sweeps, glyph pixel forced high.
        bus.msg_sel = 2'd2;
        for (int x = 200; x < 320; x += 6) begin
            set_pix(x, 224 + (x % 16), 1'b1, 1'b1);
            tick();
        end
        bus.msg_sel = 2'd1;
        for (int x = 208; x < 420; x += 8) begin
            set_pix(x, 230, 1'b1, 1'b1);
            tick();
        end
        bus.msg_sel = 2'd3;
        set_pix(224, 224, 1'b1, 1'b1);
        repeat (2) tick();
        set_pix(260, 20, 1'b0, 1'b1);
        repeat (2) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 2))
                0:       set_pix(256 + $urandom_range(0, 95), 16 + $urandom_range(0, 15),
                                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
                1:       set_pix(208 + $urandom_range(0, 207), 224 + $urandom_range(0, 15),
                                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
                default: set_pix($urandom_range(0, 1023), $urandom_range(0, 1023),
                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
            bus.msg_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin
                bus.score_left  = 7'($urandom_range(0, 127));
                bus.score_right = 7'($urandom_range(0, 127));
                bus.score_valid = 1'b1;
            end
            if (quiet >= 20 && $urandom_range(0, 7) == 0) bus.frame_start = 1'b1;
            tick();
        end
        repeat (22) tick();
        bus.frame_start = 1'b1;
        tick();
        repeat (22) tick();
        bus.frame_start = 1'b1;
        tick();

        // Reset in the middle of a conversion.
        post_scores(77, 77);
        repeat (5) tick();
        do_reset();
        set_pix(256, 16, 1'b1, 1'b0);
        tick();
        chk("abort_index", int'(bus.char_index), 13);

        // Frame pulses across the blink boundary, alternating message and score cells.
        bus.msg_sel = 2'd2;
        for (int i = 0; i < 70; i++) begin
            set_pix(224, 224, 1'b1, 1'b1);
            bus.frame_start = 1'b1;
            tick();
            set_pix(272, 16, 1'b1, 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_text_overlay.md
Name: score_text_overlay

Overview:
- Text-overlay front end for the Pong VGA path. Sits directly upstream of the glyph ROM and feeds it.
- Maps the current VGA pixel coordinate to a text cell, then drives char_index, glyph_row and glyph_column into the ROM.
- Receives the ROM's combinational pixel and returns a registered overlay_on to the colour mux.
- Converts two binary scores to decimal digits with a sequential double-dabble engine. Digits are committed only at frame start, so the displayed score never tears mid-frame.

Parameters:
- SCALE_LOG2, 1, glyph magnification as a power of two (1 gives 16x16-pixel cells).
- SCORE_ROW, 1, text-cell row of the score line.
- SCORE_COL, 16, text-cell column of the first score character.
- MSG_ROW, 14, text-cell row of the message line.
- MSG_COL, 14, text-cell column of the first message character.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current horizontal pixel coordinate
- pixel_y  in  10  current vertical pixel coordinate
- video_on  in  1  active-video qualifier
- frame_start  in  1  one-cycle pulse at the start of each frame
- score_left  in  7  left score, binary
- score_right  in  7  right score, binary
- score_valid  in  1  one-cycle pulse: sample both scores
- msg_sel  in  2  message select: 0 none, 1 "PRESS START", 2 "PAUSE", 3 none
- glyph_pixel  in  1  pixel returned by the glyph ROM
- char_index  out  6  glyph ROM character select
- glyph_row  out  3  glyph ROM row
- glyph_column  out  3  glyph ROM column
- overlay_on  out  1  text pixel lit, aligned to video_on delayed by 2 cycles
- busy  out  1  conversion or commit pending

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: char_index=31, glyph_row=0, glyph_column=0, overlay_on=0, busy=0. Displayed and shadow digits all 0. FSM in IDLE, pending flag clear.
- Cell decode (combinational):
  - cell_x = pixel_x >> (3+SCALE_LOG2); cell_y = pixel_y >> (3+SCALE_LOG2).
  - offset column = (pixel_x >> SCALE_LOG2)[2:0]; offset row = (pixel_y >> SCALE_LOG2)[2:0]. Row 0 is the top of the cell, column 0 the left.
- Character select:
  - Score line (cell_y==SCORE_ROW), columns SCORE_COL..SCORE_COL+4: L tens, L ones, colon, R tens, R ones.
  - Digit d maps to index 13+d. Colon is 12. Leading zeros are shown.
  - Message 1 at MSG_ROW from MSG_COL: P R E S S blank S T A R T, indices 0,1,2,3,3,31,3,5,4,1,5.
  - Message 2: P A U S E, indices 0,4,8,3,2.
  - Every other cell, and any cell while video_on=0, selects 31.
- Stage 1 (registered, latency 1): char_index, glyph_row, glyph_column; video_on is delayed into v1.
- Stage 2 (registered, latency 2): overlay_on <= glyph_pixel & v1.
- Score FSM states: IDLE, LOAD, SHIFT_L, SHIFT_R, WAIT_FRAME.
  - IDLE: on score_valid, capture both scores, saturating values above 99 to 99, then go to LOAD.
  - LOAD: clear the BCD accumulators.
  - SHIFT_L: 7 double-dabble iterations, one per cycle. Add 3 to any nibble >=5 before each shift.
  - SHIFT_R: same as SHIFT_L for the right score. Results go to the shadow digits.
  - WAIT_FRAME: on frame_start, copy shadow digits to the displayed digits in one cycle. Then go to LOAD if a capture is pending, otherwise IDLE.
  - busy=1 in every state except IDLE.
- score_valid while busy: capture the new scores into the pending registers. The latest value wins. Not lost.
- score_valid and frame_start in the same cycle during WAIT_FRAME: commit the old shadow digits and set pending.
- frame_start outside WAIT_FRAME is ignored by the FSM.
- msg_sel is sampled combinationally; no commit is applied to it.
- Reset mid-conversion aborts it. Displayed digits return to 0.

Optional Feature:
- Macro MSG_BLINK_EN.
- When defined: a 6-bit frame counter increments on frame_start and resets to 0. Message cells select 31 while counter[5]=1, giving 32 frames on and 32 off. The score line is unaffected.
- When undefined: no counter is present and messages are always displayed.

Test Plan:
- Reset, then pixel at the score line's left tens cell, offset column 0 -> char_index=13, glyph_row=0, glyph_column=0 one cycle later; overlay_on=0 two cycles after reset release.
- score_left=42, score_right=7, score_valid, then frame_start -> busy clears; score cells read indices 17,15,12,13,20.
- score_left=120 -> displays 99, indices 22,22.
- Second score_valid (scores 5,6) while in SHIFT_L -> first result commits on the first frame_start; 05:06 on the next; no value dropped.
- msg_sel=2, sweep the message row with glyph_pixel forced to 1 and video_on=1 -> indices 0,4,8,3,2; overlay_on=1 exactly 2 cycles after each pixel; neighbouring cells give 31.
- With MSG_BLINK_EN: after 32 frame_start pulses, message cells give 31 while the score line is unchanged.
